// File: rtl/gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gen_pkg
// Description : Shared state encoding and index-width helper for gen_deser.
// Revision    : 1.0 - initial release
// ============================================================================
package gen_pkg;

  // Controller states: assembling a word, or presenting a finished word.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  // Width of the lane index for a word of 'bits' lanes; never below 1 bit.
  function automatic int idx_width(input int bits);
    return (bits <= 2) ? 1 : $clog2(bits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gen_lane.sv
`default_nettype none
// ============================================================================
// Module      : gen_lane
// Description : One bit of lane storage with write enable and sync reset.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_lane (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic d,
  output logic q
);

  // Capture d when this lane is addressed; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gen_deser.sv
`default_nettype none
// ============================================================================
// Module      : gen_deser
// Description : Serial-to-parallel deserializer, LSB first, valid/ready on
//               both sides, zero-bubble handover from HOLD back to COLLECT.
// Revision    : 1.0 - initial release
// ============================================================================
module gen_deser
  import gen_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_bit,
  output logic            in_ready,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  input  logic            out_ready
);

  localparam int            IW       = idx_width(BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(BITS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;
  logic            in_xfer;
  logic [BITS-1:0] lane_we;
  logic [BITS-1:0] lane_q;

  // State and lane index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state, index update and handshake outputs.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        if (in_valid) begin
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // A new bit may only enter while the held word leaves.
        in_ready  = out_ready;
        if (out_ready) begin
          state_nxt = COLLECT;
          idx_nxt   = in_valid ? IW'(1) : '0;
        end
      end
      default: begin
        state_nxt = COLLECT;
        idx_nxt   = '0;
      end
    endcase
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_data = lane_q;

  // Lane storage; idx is 0 throughout HOLD, so a handover transfer lands in lane 0.
  generate
    for (genvar i = 0; i < BITS; i++) begin : g_lane
      assign lane_we[i] = in_xfer && (idx == IW'(i));
      gen_lane u_lane (
        .clk   (clk),
        .reset (reset),
        .we    (lane_we[i]),
        .d     (in_bit),
        .q     (lane_q[i])
      );
    end
  endgenerate

  logic            stall_q;
  logic [BITS-1:0] data_q;

  // Remember whether the previous cycle stalled a presented word, and its data.
  always_ff @(posedge clk) begin
    stall_q <= !reset && out_valid && !out_ready;
    data_q  <= out_data;
  end

  // Structural invariants, checked on cycle values sampled at each edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!out_valid || state == HOLD);
      assert (32'(idx) < BITS);
      assert (!stall_q || out_data == data_q);
    end
  end

endmodule
`default_nettype wire
